bus_gate_arbiter: RTL and testbench
===================================

# bus_gate_arbiter

Round-robin arbiter that owns the four gate enables of the shared 16-bit CPU data bus (MARMUX, PC, MDR, ALU drivers). Each source raises a request. The arbiter issues registered, one-hot gate signals to the bus multiplexer, so at most one driver is enabled in any cycle. A hold counter stops any single source from monopolising the bus while others wait. It sits between the control-sequencing logic and the bus multiplexer, replacing direct assertion of the Gate* lines.

## Interface
- N_REQ, 4, number of requesters; fixed index map: 0=MARMUX, 1=PC, 2=MDR, 3=ALU.
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester is pending; legal range 1..255.

- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  N_REQ  per-source bus request, level-sensitive.
- Grant  output  N_REQ  registered one-hot grant; all-zero when the bus is idle.
- GateMARMUX, GatePC, GateMDR, GateALU  output  1 each  equal to Grant[0], Grant[1], Grant[2], Grant[3].
- Grant_Id  output  2  index of the current holder; holds the last holder's index when idle.
- Bus_Busy  output  1  OR of Grant.
- Preempt  output  1  one-cycle pulse in the cycle after a holder is revoked by MAX_HOLD expiry.

## Operation
- State machine states:
  - IDLE: Grant=0.
  - OWN: exactly one Grant bit set.
  - TURN: Grant=0; exists only when the turnaround feature is compiled in.
- Round-robin search: start at (last_id+1) mod N_REQ and pick the first set Req bit. last_id is updated whenever a new grant is issued.
- IDLE:
  - If any Req is set, grant the search winner and go to OWN.
  - Otherwise stay in IDLE.
- OWN, holder still requesting:
  - The hold counter increments each cycle and saturates at MAX_HOLD.
  - If the counter has reached MAX_HOLD-1 and any other Req is set, revoke the holder. The search winner, which excludes the holder, becomes the next owner, and Preempt pulses.
  - If no other Req is set, the holder keeps the bus indefinitely.
- OWN, holder drops Req:
  - If other Req bits are set, hand over to the search winner.
  - Otherwise go to IDLE.
- Hand-over without the turnaround feature: goes straight from OWN to OWN with the new owner. The hold counter resets to 0 on every new grant.
- Any Req change in the same cycle as a grant decision is sampled as-is. There is no combinational path from Req to Grant.
- Reset (asynchronous, takes effect at any time, including mid-grant):
  - State=IDLE, Grant=0, all Gate*=0, Bus_Busy=0, Preempt=0.
  - Hold counter=0.
  - last_id=N_REQ-1, so the first search starts at MARMUX. Grant_Id=N_REQ-1.
- Invariant: $countones(Grant) <= 1 in every cycle, including reset release.

## Timing
- Grant latency: Req set in cycle t while IDLE -> Grant visible in cycle t+1.
- Release: holder Req low in cycle t -> holder Grant low in cycle t+1.
  - Without turnaround: the next owner's Grant is high in cycle t+1.
- Preemption: a holder granted in cycle g with a competitor waiting is revoked after the cycle g+MAX_HOLD-1 edge. It owns exactly MAX_HOLD cycles. Preempt is high in cycle g+MAX_HOLD.
- A preempted holder that keeps Req high re-enters arbitration normally. Under round-robin it waits behind all other pending requesters.
- Reset release: first possible grant is one cycle after the first edge with Reset_n high.

## Configuration
- BUS_TURNAROUND_EN defined:
  - Every OWN->new-owner transition and every OWN->IDLE transition passes through one TURN cycle with Grant=0.
  - The decision is made on entry to TURN; the new owner's Grant appears one cycle later. Hand-over latency is 2 cycles.
  - In TURN, a winner is re-evaluated from current Req. If none, go to IDLE.
- BUS_TURNAROUND_EN undefined:
  - TURN state is absent.
  - Hand-over is back-to-back with 1-cycle latency.

## Test plan
- Reset then Req=4'b0010 at cycle 0 -> Grant=4'b0010, GatePC=1, Grant_Id=1 at cycle 1. Hold Req for 20 cycles -> Grant unchanged, Preempt never set.
- Req=4'b1111 held constantly, MAX_HOLD=8 -> owners cycle 0,1,2,3,0. Each owns exactly 8 cycles. Preempt pulses every 8 cycles. Grant is never multi-hot.
- Owner MDR (Req=4'b0100), then Req=4'b1001 with MDR dropped in the same cycle -> next Grant=4'b1000 (ALU, first after index 2). Latency 1 cycle without macro; 2 cycles with one Grant=0 cycle with macro.
- Reset_n pulsed low mid-grant while ALU owns -> Grant=0 and Gate*=0 immediately. After release with Req=4'b1111 -> first Grant=4'b0001.
- Single holder drops Req with no others pending -> Grant=0, Bus_Busy=0, Grant_Id keeps the old index. Req=4'b0001 next -> MARMUX granted 1 cycle later.
- Random Req stimulus for 10k cycles -> assert one-hot-or-zero Grant. Assert no requester waits longer than 3*MAX_HOLD+3 cycles. With BUS_TURNAROUND_EN, assert an all-zero cycle between different owners.

Source files
------------

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the four CPU data-bus gate enables (MARMUX, PC, MDR, ALU).
// Optional one-cycle bus turnaround between owners is compiled in with BUS_TURNAROUND_EN.
module bus_gate_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic       GateMARMUX,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic [1:0] Grant_Id,
  output logic       Bus_Busy,
  output logic       Preempt
);

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

`ifdef BUS_TURNAROUND_EN
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_OWN} state_e;
`endif

  state_e             r_state,    w_state_nxt;
  logic [N_REQ-1:0]   r_grant,    w_grant_nxt;
  logic [ID_W-1:0]    r_last_id,  w_last_id_nxt;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic               r_preempt,  w_preempt_nxt;

  logic [N_REQ-1:0]   w_others;
  logic               w_found;
  logic [ID_W-1:0]    w_pick_id;
  logic               w_holder_req;
  logic               w_hold_expired;
  logic               w_take;
  logic               w_release;

  // The current holder is masked out, so a revoked holder can never win its own re-arbitration.
  assign w_others       = Req & ~r_grant;
  assign w_holder_req   = |(Req & r_grant);
  assign w_hold_expired = (r_hold_cnt >= HOLD_LAST);

  always_comb begin : rr_search
    logic [ID_W-1:0] idx;
    w_found   = 1'b0;
    w_pick_id = r_last_id;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = r_last_id + ID_W'(k);
      if (!w_found && w_others[idx]) begin
        w_found   = 1'b1;
        w_pick_id = idx;
      end
    end
  end

  // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_id_nxt  = r_last_id;
    w_hold_cnt_nxt = r_hold_cnt;
    w_preempt_nxt  = 1'b0;
    w_take         = 1'b0;
    w_release      = 1'b0;

    case (r_state)
      S_IDLE: w_take = w_found;
      S_OWN: begin
        if (w_holder_req) begin
          if (w_hold_expired && w_found) begin
            w_preempt_nxt = 1'b1;
            w_release     = 1'b1;
          end else if (r_hold_cnt < HOLD_SAT) begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
        end else begin
          w_release = 1'b1;
        end
      end
`ifdef BUS_TURNAROUND_EN
      S_TURN: begin
        w_take = w_found;
        if (!w_found) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef BUS_TURNAROUND_EN
    // Every release parks the bus for one all-zero cycle; the winner is chosen again in TURN.
    if (w_release) begin
      w_state_nxt    = S_TURN;
      w_grant_nxt    = '0;
      w_hold_cnt_nxt = '0;
    end
`else
    if (w_release) begin
      if (w_found) begin
        w_take = 1'b1;
      end else begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = '0;
        w_hold_cnt_nxt = '0;
      end
    end
`endif

    if (w_take) begin
      w_state_nxt    = S_OWN;
      w_grant_nxt    = ONE_HOT0 << w_pick_id;
      w_last_id_nxt  = w_pick_id;
      w_hold_cnt_nxt = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_last_id  <= ID_W'(N_REQ - 1);
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last_id  <= w_last_id_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  assign Grant      = r_grant;
  assign GateMARMUX = r_grant[0];
  assign GatePC     = r_grant[1];
  assign GateMDR    = r_grant[2];
  assign GateALU    = r_grant[3];
  assign Grant_Id   = r_last_id;
  assign Bus_Busy   = |r_grant;
  assign Preempt    = r_preempt;

  a_grant_onehot0: assert property (@(posedge Clk) disable iff (!Reset_n) $onehot0(r_grant));
  a_own_has_grant: assert property (@(posedge Clk) disable iff (!Reset_n)
                                    (r_state == S_OWN) |-> $onehot(r_grant));

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Scoreboard bench for bus_gate_arbiter (default build, MAX_HOLD=8): directed vectors
// with hand-computed expectations, then random Req traffic under invariant and fairness checks.
module tb_bus_gate_arbiter;

  localparam int MAX_HOLD  = 8;
  localparam int WAIT_MAX  = 3 * MAX_HOLD + 3;

  logic       Clk;
  logic       Reset_n;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic       GateMARMUX, GatePC, GateMDR, GateALU;
  logic [1:0] Grant_Id;
  logic       Bus_Busy;
  logic       Preempt;

  bus_gate_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req        (Req),
    .Grant      (Grant),
    .GateMARMUX (GateMARMUX),
    .GatePC     (GatePC),
    .GateMDR    (GateMDR),
    .GateALU    (GateALU),
    .Grant_Id   (Grant_Id),
    .Bus_Busy   (Bus_Busy),
    .Preempt    (Preempt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [1:0] id;
    logic       pre;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   wait_cnt [4];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive Req for one cycle and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] req, input logic [3:0] eg, input logic [1:0] eid,
                      input logic ep);
    exp_t e;
    @(posedge Clk);
    #1;
    Req   = req;
    e.cyc = cyc + 1;
    e.grant = eg;
    e.id  = eid;
    e.pre = ep;
    q.push_back(e);
  endtask

  // Monitor: invariants every cycle, scoreboard compare when an expectation is due.
  always @(negedge Clk) begin
    exp_t e;
    check("grant_onehot0", 32'($onehot0(Grant)), 32'd1);
    check("gates_eq_grant", {28'd0, GateALU, GateMDR, GatePC, GateMARMUX}, {28'd0, Grant});
    check("busy_eq_or", {31'd0, Bus_Busy}, {31'd0, |Grant});
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("sb_stale", e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("grant",    {28'd0, Grant},    {28'd0, e.grant});
      check("grant_id", {30'd0, Grant_Id}, {30'd0, e.id});
      check("preempt",  {31'd0, Preempt},  {31'd0, e.pre});
    end
    for (int i = 0; i < 4; i++) begin
      if (Reset_n && Req[i] && !Grant[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > WAIT_MAX) begin
        check("wait_bound", wait_cnt[i], WAIT_MAX);
        wait_cnt[i] = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    logic [1:0] owner;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    Reset_n = 1'b0;
    Req     = 4'b0000;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_grant",    {28'd0, Grant},    32'h0);
    check("rst_grant_id", {30'd0, Grant_Id}, 32'd3);
    check("rst_busy",     {31'd0, Bus_Busy}, 32'd0);
    check("rst_preempt",  {31'd0, Preempt},  32'd0);
    #2 Reset_n = 1'b1;

    // Lone PC requester: granted after one cycle, then keeps the bus indefinitely.
    step(4'b0010, 4'b0010, 2'd1, 1'b0);
    repeat (20) step(4'b0010, 4'b0010, 2'd1, 1'b0);

    // Release to idle keeps Grant_Id, then MARMUX request from idle.
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);

    // MARMUX drops for MDR; MDR drops while ALU and MARMUX request -> ALU next.
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    repeat (2) step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b1001, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);

    // All four requesting: owners 0,1,2,3,0 for exactly MAX_HOLD cycles each.
    for (int o = 0; o < 5; o++) begin
      owner = 2'(o);
      for (int k = 0; k < MAX_HOLD; k++)
        step(4'b1111, 4'b0001 << owner, owner, (k == 0 && o > 0));
    end
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // ALU owns, then asynchronous reset lands mid-grant.
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    @(posedge Clk);
    #7;
    Reset_n = 1'b0;
    Req     = 4'b0000;
    #1;
    check("midrst_grant",    {28'd0, Grant}, 32'h0);
    check("midrst_gates",    {28'd0, GateALU, GateMDR, GatePC, GateMARMUX}, 32'h0);
    check("midrst_busy",     {31'd0, Bus_Busy}, 32'd0);
    check("midrst_preempt",  {31'd0, Preempt},  32'd0);
    check("midrst_grant_id", {30'd0, Grant_Id}, 32'd3);
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    repeat (3) step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    repeat (2) @(posedge Clk);

    // Random traffic: each request line toggles with probability 1/8 per cycle.
    r = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      @(posedge Clk);
      #1;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      Req = r;
    end
    @(posedge Clk);
    #1 Req = 4'b0000;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    #1;
    check("sb_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
